// File: rtl/uart_txrx_cfg.sv
// UART transceiver with configurable frame, 16x oversampled receiver,
// TX/RX FIFOs, RX error reporting and echo loopback.
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, waiting for a tick with data queued and tx_en=1
//   TX_START  | start bit (low) for 16 ticks
//   TX_DATA   | DATA_BITS data bits, LSB first, 16 ticks each
//   TX_PARITY | parity bit for 16 ticks (only when PARITY != 0)
//   TX_STOP   | line high for STOP_BITS*16 ticks
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for the synchronised line to go low
//   RX_START  | confirm start bit at mid-bit, else treat as a glitch
//   RX_DATA   | sample DATA_BITS bits at mid-bit
//   RX_PARITY | sample parity bit at mid-bit
//   RX_STOP   | sample stop bit at mid-bit, push word, return to idle

module uart_txrx_cfg_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             sys_clk,
   input  logic             sys_nrst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   // head word reads as zero when empty so outputs are clean out of reset
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // pointer update; writes into a full FIFO are dropped
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage array, no reset needed since empty masks the head
   always_ff @(posedge sys_clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

module uart_txrx_cfg #(
   parameter int CLK_DIV   = 8,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_nrst,
   input  logic                 lp_mode,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   input  logic                 tx_en,
   output logic                 tx_busy,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
   input  logic                 err_clr,
   output logic                 TX,
   input  logic                 RX
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [4:0] BIT_LAST  = 5'd15;
   localparam logic [4:0] STOP_LAST = 5'(16*STOP_BITS-1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS-1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   logic [DW-1:0] div_cnt;
   logic          tick;

   logic                 txf_wr, txf_rd, txf_empty, txf_full;
   logic [DATA_BITS-1:0] txf_wdata, txf_rdata;
   logic                 rxf_wr, rxf_rd, rxf_empty, rxf_full;
   logic [DATA_BITS+1:0] rxf_rdata;

   tx_state_t            tx_state, tx_state_nxt;
   logic [4:0]           tx_cnt, tx_cnt_nxt;
   logic [2:0]           tx_bit, tx_bit_nxt;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
   logic                 tx_par, tx_par_nxt;
   logic                 tx_line, tx_line_nxt;

   logic                 rx_meta, rx_s;
   rx_state_t            rx_state, rx_state_nxt;
   logic [3:0]           rx_cnt, rx_cnt_nxt;
   logic [2:0]           rx_bit, rx_bit_nxt;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
   logic                 rx_pbit, rx_pbit_nxt;
   logic                 rx_lp_q, rx_lp_nxt;
   logic                 rx_push;
   logic                 rx_ferr, rx_perr;
   logic                 lb_push;
   logic                 ovr_set;

   // free-running oversample tick
   assign tick = (div_cnt == DW'(CLK_DIV-1));

   always_ff @(posedge sys_clk) begin
      if (!sys_nrst)  div_cnt <= '0;
      else if (tick)  div_cnt <= '0;
      else            div_cnt <= div_cnt + 1'b1;
   end

   // loopback words take priority over host writes into the TX FIFO
   assign lb_push   = rx_push & rx_lp_q;
   assign txf_wr    = lb_push | (tx_valid & ~lp_mode);
   assign txf_wdata = lb_push ? rx_shift : tx_data;
   assign tx_ready  = ~txf_full & ~lp_mode;

   assign rxf_wr    = rx_push & ~rx_lp_q;
   assign rx_valid  = ~rxf_empty & ~lp_mode;
   assign rxf_rd    = rx_valid & rx_ready;
   assign {rx_frame_err, rx_parity_err, rx_data} = rxf_rdata;

   assign ovr_set   = (lb_push & txf_full) | (rxf_wr & rxf_full);

   uart_txrx_cfg_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .sys_clk (sys_clk),
      .sys_nrst(sys_nrst),
      .wr_en   (txf_wr),
      .wr_data (txf_wdata),
      .rd_en   (txf_rd),
      .rd_data (txf_rdata),
      .empty   (txf_empty),
      .full    (txf_full)
   );

   uart_txrx_cfg_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .sys_clk (sys_clk),
      .sys_nrst(sys_nrst),
      .wr_en   (rxf_wr),
      .wr_data ({rx_ferr, rx_perr, rx_shift}),
      .rd_en   (rxf_rd),
      .rd_data (rxf_rdata),
      .empty   (rxf_empty),
      .full    (rxf_full)
   );

   // TX state and datapath registers
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx_line  <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_bit   <= tx_bit_nxt;
         tx_shift <= tx_shift_nxt;
         tx_par   <= tx_par_nxt;
         tx_line  <= tx_line_nxt;
      end
   end

   // TX next state; tx_cnt is a per-bit down-counter of ticks
   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_bit_nxt   = tx_bit;
      tx_shift_nxt = tx_shift;
      tx_par_nxt   = tx_par;
      tx_line_nxt  = tx_line;
      txf_rd       = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_line_nxt = 1'b1;
            if (tick && tx_en && !txf_empty) begin
               txf_rd       = 1'b1;
               tx_shift_nxt = txf_rdata;
               tx_par_nxt   = (PARITY == 1) ? ~(^txf_rdata) : ^txf_rdata;
               tx_cnt_nxt   = BIT_LAST;
               tx_line_nxt  = 1'b0;
               tx_state_nxt = TX_START;
            end
         end
         TX_START: begin
            if (tick) begin
               if (tx_cnt == 5'd0) begin
                  tx_cnt_nxt   = BIT_LAST;
                  tx_bit_nxt   = 3'd0;
                  tx_line_nxt  = tx_shift[0];
                  tx_state_nxt = TX_DATA;
               end else begin
                  tx_cnt_nxt = tx_cnt - 5'd1;
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_cnt == 5'd0) begin
                  tx_cnt_nxt = BIT_LAST;
                  if (tx_bit == DATA_LAST) begin
                     if (PARITY != 0) begin
                        tx_line_nxt  = tx_par;
                        tx_state_nxt = TX_PARITY;
                     end else begin
                        tx_cnt_nxt   = STOP_LAST;
                        tx_line_nxt  = 1'b1;
                        tx_state_nxt = TX_STOP;
                     end
                  end else begin
                     tx_bit_nxt   = tx_bit + 3'd1;
                     tx_shift_nxt = tx_shift >> 1;
                     tx_line_nxt  = tx_shift[1];
                  end
               end else begin
                  tx_cnt_nxt = tx_cnt - 5'd1;
               end
            end
         end
         TX_PARITY: begin
            if (tick) begin
               if (tx_cnt == 5'd0) begin
                  tx_cnt_nxt   = STOP_LAST;
                  tx_line_nxt  = 1'b1;
                  tx_state_nxt = TX_STOP;
               end else begin
                  tx_cnt_nxt = tx_cnt - 5'd1;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_cnt == 5'd0) begin
                  tx_line_nxt  = 1'b1;
                  tx_state_nxt = TX_IDLE;
               end else begin
                  tx_cnt_nxt = tx_cnt - 5'd1;
               end
            end
         end
         default: begin
            tx_line_nxt  = 1'b1;
            tx_state_nxt = TX_IDLE;
         end
      endcase
   end

   assign tx_busy = (tx_state != TX_IDLE);
   assign TX      = tx_line;

   // two-flop synchroniser, idles high
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   // RX state and datapath registers
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_pbit  <= 1'b0;
         rx_lp_q  <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_bit   <= rx_bit_nxt;
         rx_shift <= rx_shift_nxt;
         rx_pbit  <= rx_pbit_nxt;
         rx_lp_q  <= rx_lp_nxt;
      end
   end

   // RX next state; rx_cnt counts ticks within a bit, sample at 7
   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_bit_nxt   = rx_bit;
      rx_shift_nxt = rx_shift;
      rx_pbit_nxt  = rx_pbit;
      rx_lp_nxt    = rx_lp_q;
      rx_push      = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_cnt_nxt   = 4'd0;
               rx_lp_nxt    = lp_mode;
               rx_state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (tick) begin
               rx_cnt_nxt = rx_cnt + 4'd1;
               if (rx_cnt == 4'd7 && rx_s) begin
                  rx_state_nxt = RX_IDLE;
               end else if (rx_cnt == 4'd15) begin
                  rx_bit_nxt   = 3'd0;
                  rx_state_nxt = RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               rx_cnt_nxt = rx_cnt + 4'd1;
               if (rx_cnt == 4'd7) rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
               if (rx_cnt == 4'd15) begin
                  if (rx_bit == DATA_LAST)
                     rx_state_nxt = (PARITY != 0) ? RX_PARITY : RX_STOP;
                  else
                     rx_bit_nxt = rx_bit + 3'd1;
               end
            end
         end
         RX_PARITY: begin
            if (tick) begin
               rx_cnt_nxt = rx_cnt + 4'd1;
               if (rx_cnt == 4'd7)  rx_pbit_nxt  = rx_s;
               if (rx_cnt == 4'd15) rx_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (tick) begin
               rx_cnt_nxt = rx_cnt + 4'd1;
               if (rx_cnt == 4'd7) begin
                  rx_push      = 1'b1;
                  rx_state_nxt = RX_IDLE;
               end
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   assign rx_ferr = ~rx_s;
   assign rx_perr = (PARITY == 0) ? 1'b0 :
                    (PARITY == 1) ? ~(^{rx_shift, rx_pbit}) : ^{rx_shift, rx_pbit};

   // sticky overrun; a new drop beats a simultaneous clear
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst)    rx_overrun <= 1'b0;
      else if (ovr_set) rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
   end
endmodule

// File: tb/tb_uart_txrx_cfg.sv
// Directed bench: instance A is 8N1, instance B is 8E1, both CLK_DIV=4.
module tb_uart_txrx_cfg;
   localparam int CD  = 4;
   localparam int BIT = 16*CD;

   logic sys_clk = 1'b0;
   logic sys_nrst = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic       lp_mode_a, tx_valid_a, tx_ready_a, tx_en_a, tx_busy_a;
   logic       rx_valid_a, rx_ready_a, rx_ferr_a, rx_perr_a, rx_ovr_a, err_clr_a, tx_a;
   logic [7:0] tx_data_a, rx_data_a;
   logic       lp_mode_b, tx_valid_b, tx_ready_b, tx_en_b, tx_busy_b;
   logic       rx_valid_b, rx_ready_b, rx_ferr_b, rx_perr_b, rx_ovr_b, err_clr_b, tx_b;
   logic [7:0] tx_data_b, rx_data_b;
   logic [1:0] rx_pin;

   int n_tests = 0;
   int n_fail  = 0;

   uart_txrx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .TX_DEPTH(4), .RX_DEPTH(4)) u_dut_a (
      .sys_clk(sys_clk), .sys_nrst(sys_nrst), .lp_mode(lp_mode_a),
      .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
      .tx_en(tx_en_a), .tx_busy(tx_busy_a), .rx_valid(rx_valid_a),
      .rx_ready(rx_ready_a), .rx_data(rx_data_a), .rx_frame_err(rx_ferr_a),
      .rx_parity_err(rx_perr_a), .rx_overrun(rx_ovr_a), .err_clr(err_clr_a),
      .TX(tx_a), .RX(rx_pin[0])
   );

   uart_txrx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                   .TX_DEPTH(4), .RX_DEPTH(4)) u_dut_b (
      .sys_clk(sys_clk), .sys_nrst(sys_nrst), .lp_mode(lp_mode_b),
      .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
      .tx_en(tx_en_b), .tx_busy(tx_busy_b), .rx_valid(rx_valid_b),
      .rx_ready(rx_ready_b), .rx_data(rx_data_b), .rx_frame_err(rx_ferr_b),
      .rx_parity_err(rx_perr_b), .rx_overrun(rx_ovr_b), .err_clr(err_clr_b),
      .TX(tx_b), .RX(rx_pin[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic tx_of(input int w);
      return (w == 0) ? tx_a : tx_b;
   endfunction

   task automatic run_len(input int w, input logic lvl, input int bound, output int n);
      n = 0;
      while (tx_of(w) == lvl && n < bound) begin
         @(negedge sys_clk);
         n++;
      end
   endtask

   task automatic wait_fall(input int w, input string tag);
      int n = 0;
      while (tx_of(w) == 1'b1 && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      chk(tag, 32'(tx_of(w)), 32'd0);
   endtask

   // runs alternate starting with the start bit low; a final run of 300 means "still high at bound"
   task automatic check_frame(input int w, input string tag, input int runs[8], input int nr);
      logic lvl = 1'b0;
      int   n;
      wait_fall(w, {tag, "_start"});
      for (int i = 0; i < nr; i++) begin
         run_len(w, lvl, (i == nr-1) ? 300 : 1000, n);
         chk($sformatf("%s_run%0d", tag, i), n, runs[i]);
         lvl = ~lvl;
      end
   endtask

   task automatic push_word(input int w, input logic [7:0] d);
      @(negedge sys_clk);
      if (w == 0) begin tx_valid_a = 1'b1; tx_data_a = d; end
      else        begin tx_valid_b = 1'b1; tx_data_b = d; end
      @(negedge sys_clk);
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
   endtask

   task automatic rx_frame(input int w, input logic [7:0] d, input bit has_par,
                           input logic pbit, input logic stop, input int stop_ticks);
      @(negedge sys_clk);
      rx_pin[w] = 1'b0;
      repeat (BIT) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin[w] = d[i];
         repeat (BIT) @(negedge sys_clk);
      end
      if (has_par) begin
         rx_pin[w] = pbit;
         repeat (BIT) @(negedge sys_clk);
      end
      rx_pin[w] = stop;
      repeat (stop_ticks*CD) @(negedge sys_clk);
      rx_pin[w] = 1'b1;
      repeat (BIT/2) @(negedge sys_clk);
   endtask

   task automatic pop(input int w);
      @(negedge sys_clk);
      if (w == 0) rx_ready_a = 1'b1; else rx_ready_b = 1'b1;
      @(negedge sys_clk);
      rx_ready_a = 1'b0;
      rx_ready_b = 1'b0;
   endtask

   initial begin
      int r[8];
      int n;
      logic [7:0] exp_d;
      lp_mode_a = 0; tx_valid_a = 0; tx_data_a = 0; tx_en_a = 1; rx_ready_a = 0; err_clr_a = 0;
      lp_mode_b = 0; tx_valid_b = 0; tx_data_b = 0; tx_en_b = 1; rx_ready_b = 0; err_clr_b = 0;
      rx_pin = 2'b11;
      repeat (5) @(negedge sys_clk);

      chk("rst_tx", 32'(tx_a), 32'd1);
      chk("rst_busy", 32'(tx_busy_a), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid_a), 32'd0);
      chk("rst_rx_data", 32'(rx_data_a), 32'd0);
      chk("rst_ferr", 32'(rx_ferr_a), 32'd0);
      chk("rst_perr", 32'(rx_perr_a), 32'd0);
      chk("rst_ovr", 32'(rx_ovr_a), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready_a), 32'd1);
      sys_nrst = 1'b1;
      repeat (5) @(negedge sys_clk);

      // 0xA5 LSB first: 1,0,1,0,0,1,0,1
      push_word(0, 8'hA5);
      r = '{64, 64, 64, 64, 128, 64, 64, 300};
      check_frame(0, "tx_a5", r, 8);
      chk("tx_a5_idle_busy", 32'(tx_busy_a), 32'd0);

      rx_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 16);
      chk("rx5a_valid", 32'(rx_valid_a), 32'd1);
      chk("rx5a_data", 32'(rx_data_a), 32'h5A);
      chk("rx5a_ferr", 32'(rx_ferr_a), 32'd0);
      chk("rx5a_perr", 32'(rx_perr_a), 32'd0);
      pop(0);
      chk("rx5a_popped", 32'(rx_valid_a), 32'd0);

      rx_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 12);
      chk("ferr_valid", 32'(rx_valid_a), 32'd1);
      chk("ferr_data", 32'(rx_data_a), 32'h3C);
      chk("ferr_flag", 32'(rx_ferr_a), 32'd1);
      pop(0);
      repeat (200) @(negedge sys_clk);
      chk("ferr_no_ghost", 32'(rx_valid_a), 32'd0);

      @(negedge sys_clk);
      rx_pin[0] = 1'b0;
      repeat (3*CD) @(negedge sys_clk);
      rx_pin[0] = 1'b1;
      repeat (200) @(negedge sys_clk);
      chk("glitch_no_word", 32'(rx_valid_a), 32'd0);

      for (int i = 0; i < 4; i++) begin
         exp_d = 8'(8'h11 * (i+1));
         rx_frame(0, exp_d, 1'b0, 1'b0, 1'b1, 16);
      end
      chk("ovr_at_full", 32'(rx_ovr_a), 32'd0);
      rx_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 16);
      chk("ovr_set", 32'(rx_ovr_a), 32'd1);
      for (int i = 0; i < 4; i++) begin
         exp_d = 8'(8'h11 * (i+1));
         chk($sformatf("ovr_valid%0d", i), 32'(rx_valid_a), 32'd1);
         chk($sformatf("ovr_data%0d", i), 32'(rx_data_a), 32'(exp_d));
         pop(0);
      end
      chk("ovr_drained", 32'(rx_valid_a), 32'd0);
      @(negedge sys_clk);
      err_clr_a = 1'b1;
      @(negedge sys_clk);
      err_clr_a = 1'b0;
      chk("ovr_cleared", 32'(rx_ovr_a), 32'd0);

      // loopback: 0x3C LSB first 0,0,1,1,1,1,0,0
      @(negedge sys_clk);
      lp_mode_a = 1'b1;
      tx_en_a = 1'b0;
      @(negedge sys_clk);
      chk("lp_tx_ready", 32'(tx_ready_a), 32'd0);
      rx_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 16);
      chk("lp_rx_valid", 32'(rx_valid_a), 32'd0);
      repeat (300) @(negedge sys_clk);
      chk("lp_hold_tx", 32'(tx_a), 32'd1);
      chk("lp_hold_busy", 32'(tx_busy_a), 32'd0);
      tx_en_a = 1'b1;
      r = '{192, 256, 128, 300, 0, 0, 0, 0};
      check_frame(0, "lp_3c", r, 4);
      lp_mode_a = 1'b0;
      @(negedge sys_clk);
      chk("lp_not_in_rxfifo", 32'(rx_valid_a), 32'd0);

      // even parity: 0x55 has four ones, so parity bit 1 is wrong
      rx_frame(1, 8'h55, 1'b1, 1'b1, 1'b1, 16);
      chk("par55_valid", 32'(rx_valid_b), 32'd1);
      chk("par55_data", 32'(rx_data_b), 32'h55);
      chk("par55_perr", 32'(rx_perr_b), 32'd1);
      chk("par55_ferr", 32'(rx_ferr_b), 32'd0);
      pop(1);
      rx_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 16);
      chk("par07_data", 32'(rx_data_b), 32'h07);
      chk("par07_perr", 32'(rx_perr_b), 32'd0);
      pop(1);
      // 0x07: 1,1,1,0,0,0,0,0 then parity 1 and stop 1
      push_word(1, 8'h07);
      r = '{64, 192, 320, 300, 0, 0, 0, 0};
      check_frame(1, "txb_07", r, 4);

      push_word(0, 8'hA5);
      push_word(0, 8'h5A);
      wait_fall(0, "rst_mid_start");
      repeat (40) @(negedge sys_clk);
      chk("rst_mid_low", 32'(tx_a), 32'd0);
      sys_nrst = 1'b0;
      @(negedge sys_clk);
      chk("rst_mid_tx", 32'(tx_a), 32'd1);
      chk("rst_mid_busy", 32'(tx_busy_a), 32'd0);
      chk("rst_mid_ready", 32'(tx_ready_a), 32'd1);
      @(negedge sys_clk);
      sys_nrst = 1'b1;
      run_len(0, 1'b1, 300, n);
      chk("rst_fifo_empty", n, 300);
      push_word(0, 8'h3C);
      r = '{192, 256, 128, 300, 0, 0, 0, 0};
      check_frame(0, "post_rst", r, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
